// File: rtl/pattern_sequencer.sv
// Beat sequencer for the rhythm game: divides CLOCK50M into beats and emits an
// LFSR-derived one-hot lane pattern per beat, then one trailing rest beat.
module pattern_sequencer #(
  parameter int unsigned TICK_DIV   = 12500000,
  parameter int unsigned NOTE_COUNT = 64,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       CLOCK50M,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  output logic       game_tick,
  output logic [7:0] pattern,
  output logic [7:0] notes_left,
  output logic       playing,
  output logic       done
);

  // state   | meaning
  // IDLE    | after reset, waiting for start
  // PLAYING | issuing note beats, LFSR advances per beat
  // FLUSH   | one extra rest beat so the scorer can decay
  // DONE    | song complete, waiting for start to replay
  typedef enum logic [1:0] {IDLE, PLAYING, FLUSH, DONE} state_t;

  localparam logic [23:0] CNT_LAST   = 24'(TICK_DIV - 1);
  localparam logic [7:0]  NOTES_INIT = 8'(NOTE_COUNT);
  localparam logic [15:0] LFSR_MASK  = 16'hB400;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        tick_q, tick_d;
  logic [7:0]  pattern_q, pattern_d;
  logic [7:0]  notes_q, notes_d;

  logic [15:0] lfsr_next;
  logic        active;
  logic        beat_edge;

  always_comb begin
    lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    active    = (state_q == PLAYING) || (state_q == FLUSH);
    beat_edge = active && !pause && (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    tick_d    = 1'b0;
    pattern_d = pattern_q;
    notes_d   = notes_q;

    if (active && !pause) begin
      cnt_d = beat_edge ? 24'd0 : cnt_q + 24'd1;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) pattern_d = 8'h00;
        if (start) begin
          state_d   = PLAYING;
          cnt_d     = 24'd0;
          notes_d   = NOTES_INIT;
          lfsr_d    = LFSR_SEED;
          pattern_d = 8'h00;
        end
      end
      PLAYING: begin
        if (beat_edge) begin
          tick_d    = 1'b1;
          lfsr_d    = lfsr_next;
          pattern_d = (lfsr_next[15:14] == 2'b00) ? 8'h00 : (8'h01 << lfsr_next[2:0]);
          notes_d   = (notes_q != 8'd0) ? notes_q - 8'd1 : 8'd0;
          if (notes_q <= 8'd1) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Final rest beat; LFSR intentionally left untouched.
        if (beat_edge) begin
          tick_d    = 1'b1;
          pattern_d = 8'h00;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 24'd0;
      lfsr_q    <= LFSR_SEED;
      tick_q    <= 1'b0;
      pattern_q <= 8'h00;
      notes_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      tick_q    <= tick_d;
      pattern_q <= pattern_d;
      notes_q   <= notes_d;
    end
  end

  assign game_tick  = tick_q;
  assign pattern    = pattern_q;
  assign notes_left = notes_q;
  assign playing    = (state_q == PLAYING) || (state_q == FLUSH);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: short song (TICK_DIV=4, NOTE_COUNT=3)
// plus a long song (TICK_DIV=2, NOTE_COUNT=255) for the width check.
module tb_pattern_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, pause;
  logic       tick, playing, done;
  logic [7:0] pattern, notes;

  logic       rst_w_n, start_w;
  logic       tick_w, playing_w, done_w;
  logic [7:0] pattern_w, notes_w;

  int n_checks = 0;
  int n_fail   = 0;

  pattern_sequencer #(.TICK_DIV(4), .NOTE_COUNT(3), .LFSR_SEED(16'hACE1)) dut (
    .CLOCK50M(clk), .reset_n(rst_n), .start(start), .pause(pause),
    .game_tick(tick), .pattern(pattern), .notes_left(notes),
    .playing(playing), .done(done)
  );

  pattern_sequencer #(.TICK_DIV(2), .NOTE_COUNT(255), .LFSR_SEED(16'hACE1)) dut_w (
    .CLOCK50M(clk), .reset_n(rst_w_n), .start(start_w), .pause(1'b0),
    .game_tick(tick_w), .pattern(pattern_w), .notes_left(notes_w),
    .playing(playing_w), .done(done_w)
  );

  // Hand-derived: ACE1 -> E270 (lane 0), 7138 (lane 0), 389C (rest), then flush rest.
  logic [7:0] exp_pat   [4] = '{8'h01, 8'h01, 8'h00, 8'h00};
  logic [7:0] exp_notes [4] = '{8'd2, 8'd1, 8'd0, 8'd0};

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_tick(input int budget, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!tick && cyc < budget);
    chk_eq("tick_seen", {31'd0, tick}, 32'd1);
  endtask

  task automatic play_song(input string tag, input bit hold_start);
    int cyc;
    start = 1'b1;
    step();
    start = hold_start;
    chk_eq({tag, "_entry_playing"}, {31'd0, playing}, 32'd1);
    chk_eq({tag, "_entry_notes"}, {24'd0, notes}, 32'd3);
    chk_eq({tag, "_entry_pattern"}, {24'd0, pattern}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wait_tick(10, cyc);
      chk_eq({tag, "_gap"}, cyc, 32'd4);
      chk_eq({tag, "_pattern"}, {24'd0, pattern}, {24'd0, exp_pat[i]});
      chk_eq({tag, "_notes"}, {24'd0, notes}, {24'd0, exp_notes[i]});
      chk_eq({tag, "_playing"}, {31'd0, playing}, (i < 3) ? 32'd1 : 32'd0);
      chk_eq({tag, "_done"}, {31'd0, done}, (i == 3) ? 32'd1 : 32'd0);
      if (i == 3) start = 1'b0;
    end
    for (int i = 0; i < 12; i++) begin
      step();
      chk_eq({tag, "_post_tick"}, {31'd0, tick}, 32'd0);
    end
    chk_eq({tag, "_post_done"}, {31'd0, done}, 32'd1);
    chk_eq({tag, "_post_pattern"}, {24'd0, pattern}, 32'd0);
  endtask

  initial begin
    int cyc;
    int k;
    rst_n = 1'b0; start = 1'b0; pause = 1'b0;
    rst_w_n = 1'b0; start_w = 1'b0;
    step(); step();
    chk_eq("rst_tick", {31'd0, tick}, 32'd0);
    chk_eq("rst_pattern", {24'd0, pattern}, 32'd0);
    chk_eq("rst_notes", {24'd0, notes}, 32'd0);
    chk_eq("rst_playing", {31'd0, playing}, 32'd0);
    chk_eq("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1; rst_w_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_eq("idle_no_tick", {30'd0, tick, playing}, 32'd0);
    end

    play_song("song1", 1'b0);
    play_song("song2_hold", 1'b1);

    // Pause one cycle into the first beat of a fresh song.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_tick(10, cyc);
    chk_eq("p_first_gap", cyc, 32'd4);
    chk_eq("p_first_pat", {24'd0, pattern}, 32'h01);
    step();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_eq("p_hold_tick", {31'd0, tick}, 32'd0);
      chk_eq("p_hold_pat", {24'd0, pattern}, 32'h01);
      chk_eq("p_hold_notes", {24'd0, notes}, 32'd2);
    end
    pause = 1'b0;
    wait_tick(10, cyc);
    chk_eq("p_resume_gap", cyc, 32'd3);
    chk_eq("p_resume_pat", {24'd0, pattern}, 32'h01);
    chk_eq("p_resume_notes", {24'd0, notes}, 32'd1);

    // Reset dropped in the cycle of a tick.
    wait_tick(10, cyc);
    chk_eq("r_pre_tick", {24'd0, notes}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk_eq("r_async_outs", {13'd0, tick, pattern, notes, playing, done}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_eq("r_idle_outs", {30'd0, tick, playing}, 32'd0);
    end
    chk_eq("r_idle_done", {31'd0, done}, 32'd0);

    // start with pause held in IDLE: enter PLAYING but stay frozen.
    start = 1'b1; pause = 1'b1;
    step();
    start = 1'b0;
    chk_eq("sp_playing", {31'd0, playing}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk_eq("sp_frozen_tick", {31'd0, tick}, 32'd0);
    end
    pause = 1'b0;
    wait_tick(10, cyc);
    chk_eq("sp_gap", cyc, 32'd4);
    chk_eq("sp_pattern", {24'd0, pattern}, 32'h01);

    // Long song on the second instance.
    start_w = 1'b1;
    step();
    start_w = 1'b0;
    chk_eq("w_entry_notes", {24'd0, notes_w}, 32'd255);
    k = 0;
    cyc = 0;
    while (k < 256 && cyc < 2000) begin
      step();
      cyc++;
      if (tick_w) begin
        k++;
        chk_eq("w_notes", {24'd0, notes_w}, (k <= 255) ? 32'(255 - k) : 32'd0);
      end
    end
    chk_eq("w_tick_count", k, 32'd256);
    chk_eq("w_done", {31'd0, done_w}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick_w) k++;
    end
    chk_eq("w_no_extra_ticks", k, 32'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
